// File: rtl/udp_pkg.sv
// Shared definitions for the UDP payload datapath: byte width, payload limit
// and the TX arbiter state encoding.
package udp_pkg;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int UDP_BYTE_W      = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request found scanning
// upward from last_grant+1, wrapping modulo N_SRC.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int IDW   = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDW-1:0]   last_grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             any_req
);

  always_comb begin
    int unsigned w_idx;
    logic        w_found;
    w_idx     = '0;
    w_found   = 1'b0;
    grant_idx = last_grant;
    // k = N_SRC lands back on last_grant, so it only wins when it is the sole requester
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      w_idx = 32'(last_grant) + k;
      if (w_idx >= N_SRC) w_idx = w_idx - N_SRC;
      if (!w_found && req[w_idx[IDW-1:0]]) begin
        grant_idx = w_idx[IDW-1:0];
        w_found   = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP payload byte stream between N_SRC sources,
// with per-packet length limit and a fixed inter-packet idle gap.
//
// state | meaning
// IDLE  | no packet in flight, waiting for any src_req
// GRANT | one cycle: latch next round-robin winner, clear length count
// XFER  | granted source wired through to the framer
// DRAIN | packet truncated at MAX_LEN; swallow remaining bytes up to last
// GAP   | GAP_CYCLES idle cycles so the framer can close the datagram
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int MAX_LEN    = UDP_MAX_PAYLOAD,
  parameter int GAP_CYCLES = 12,
  parameter int IDW        = $clog2(N_SRC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            src_req,
  input  logic [UDP_BYTE_W*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]            src_valid,
  input  logic [N_SRC-1:0]            src_last,
  output logic [N_SRC-1:0]            src_ready,
  output logic [UDP_BYTE_W-1:0]       udp_data,
  output logic                        udp_valid,
  output logic                        udp_last,
  input  logic                        udp_ready,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy,
  output logic                        err_len
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [2:0]            r_state;
  logic [IDW-1:0]        r_grant;
  logic [IDW-1:0]        r_last_grant;
  logic [10:0]           r_len;
  logic [GW-1:0]         r_gap;

  logic [IDW-1:0]        w_pick;
  logic                  w_any_req;
  logic [UDP_BYTE_W-1:0] w_sel_data;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic                  w_in_xfer;
  logic                  w_in_drain;
  logic                  w_beat;
  logic                  w_len_tc;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDW   (IDW)
  ) u_rr_pick (
    .req        (src_req),
    .last_grant (r_last_grant),
    .grant_idx  (w_pick),
    .any_req    (w_any_req)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_data  = src_data[i*UDP_BYTE_W +: UDP_BYTE_W];
        w_sel_valid = src_valid[i];
        w_sel_last  = src_last[i];
      end
    end
  end

  assign w_in_xfer  = (r_state == ST_XFER);
  assign w_in_drain = (r_state == ST_DRAIN);
  assign w_beat     = w_in_xfer & w_sel_valid & udp_ready;
  assign w_len_tc   = (r_len == 11'(MAX_LEN - 1));

  assign udp_data  = w_in_xfer ? w_sel_data : '0;
  assign udp_valid = w_in_xfer & w_sel_valid;
  assign udp_last  = udp_valid & (w_sel_last | w_len_tc);
  assign err_len   = w_beat & w_len_tc & ~w_sel_last;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant;

  // DRAIN accepts regardless of udp_ready: those bytes never reach the framer
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == IDW'(i)) src_ready[i] = (w_in_xfer & udp_ready) | w_in_drain;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDW'(N_SRC - 1);
      r_len        <= '0;
      r_gap        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) r_state <= ST_GRANT;
        end
        ST_GRANT: begin
          r_len <= '0;
          if (w_any_req) begin
            r_grant <= w_pick;
            r_state <= ST_XFER;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (w_beat) begin
            if (w_sel_last) begin
              r_last_grant <= r_grant;
              r_gap        <= GW'(GAP_CYCLES - 1);
              r_state      <= ST_GAP;
            end else if (w_len_tc) begin
              r_state <= ST_DRAIN;
            end else begin
              r_len <= r_len + 11'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_sel_valid && w_sel_last) begin
            r_last_grant <= r_grant;
            r_gap        <= GW'(GAP_CYCLES - 1);
            r_state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) r_state <= w_any_req ? ST_GRANT : ST_IDLE;
          else             r_gap   <= r_gap - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: a full-size instance and a MAX_LEN=8
// instance share stimulus; each test checks the instance selected by sel8.
module tb_udp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  src_req = '0, src_valid = '0, src_last = '0;
  logic [31:0] src_data = '0;
  logic        udp_ready = 1'b1;

  logic [3:0] a_ready, b_ready;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_err, b_err;
  logic [1:0] a_gid, b_gid;

  udp_tx_arbiter #(.N_SRC(4), .MAX_LEN(1472), .GAP_CYCLES(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(a_ready),
    .udp_data(a_data), .udp_valid(a_valid), .udp_last(a_last), .udp_ready(udp_ready),
    .grant_id(a_gid), .busy(a_busy), .err_len(a_err));

  udp_tx_arbiter #(.N_SRC(4), .MAX_LEN(8), .GAP_CYCLES(12)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(b_ready),
    .udp_data(b_data), .udp_valid(b_valid), .udp_last(b_last), .udp_ready(udp_ready),
    .grant_id(b_gid), .busy(b_busy), .err_len(b_err));

  initial forever #5 clk = ~clk;

  bit         sel8 = 1'b0;
  logic [3:0] m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_busy, m_err;
  logic [1:0] m_gid;
  assign m_ready = sel8 ? b_ready : a_ready;
  assign m_data  = sel8 ? b_data  : a_data;
  assign m_valid = sel8 ? b_valid : a_valid;
  assign m_last  = sel8 ? b_last  : a_last;
  assign m_busy  = sel8 ? b_busy  : a_busy;
  assign m_err   = sel8 ? b_err   : a_err;
  assign m_gid   = sel8 ? b_gid   : a_gid;

  logic [7:0] mem [4][16];
  int         plen [4];
  int         ptr [4];
  bit         active [4];
  bit         cont [4];

  logic [7:0] lg_data [64];
  bit         lg_last [64];
  bit         lg_err [64];
  logic [1:0] lg_gid [64];
  int         lg_cyc [64];
  int         nb, err_cnt, cyc;
  bit         smp_busy;
  int         n_checks = 0, n_errors = 0;

  task automatic drive_src();
    for (int s = 0; s < 4; s++) begin
      src_req[s]        = active[s];
      src_valid[s]      = active[s];
      src_data[s*8 +: 8] = active[s] ? mem[s][ptr[s]] : 8'h00;
      src_last[s]       = active[s] && (ptr[s] == plen[s] - 1);
    end
  endtask

  task automatic load_pkt(input int s, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) mem[s][i] = base + 8'(i);
    plen[s] = len;
    ptr[s]  = 0;
  endtask

  // sample current cycle, clock once, then advance source pointers on accepted bytes
  task automatic step();
    bit acc [4];
    #1;
    smp_busy = m_busy;
    if (m_err) err_cnt++;
    if (m_valid && udp_ready && nb < 64) begin
      lg_data[nb] = m_data; lg_last[nb] = m_last; lg_err[nb] = m_err;
      lg_gid[nb]  = m_gid;  lg_cyc[nb]  = cyc;    nb++;
    end
    for (int s = 0; s < 4; s++) acc[s] = m_ready[s] && src_valid[s];
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < 4; s++) begin
      if (acc[s]) begin
        if (ptr[s] == plen[s] - 1) begin
          ptr[s] = 0;
          if (!cont[s]) active[s] = 1'b0;
        end else begin
          ptr[s]++;
        end
      end
    end
    drive_src();
  endtask

  task automatic clear_log();
    nb = 0;
    err_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    udp_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin active[s] = 0; cont[s] = 0; ptr[s] = 0; plen[s] = 1; end
    drive_src();
    step();
    step();
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    sel8 = 1'b0;
    rst_n = 1'b0;
    load_pkt(0, 3, 8'h30);
    active[0] = 1;
    drive_src();
    step();
    step();
    #1;
    n_checks++; if (m_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_checks++; if (m_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b want 0", m_last); end
    n_checks++; if (m_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", m_err); end
    n_checks++; if (m_ready !== 4'h0) begin n_errors++; $display("FAIL reset_src_ready: got %h want 0", m_ready); end
    n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", m_data); end
    n_checks++; if (m_gid !== 2'd0) begin n_errors++; $display("FAIL reset_grant: got %0d want 0", m_gid); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    string hw = "Hello World";
    int rc, k, n;
    do_reset();
    sel8 = 1'b0;
    for (int i = 0; i < 11; i++) mem[2][i] = hw[i];
    plen[2] = 11; ptr[2] = 0;
    active[2] = 1;
    drive_src();
    rc = cyc;
    k = 0;
    while (nb < 11 && k < 80) begin step(); k++; end
    n_checks++; if (nb !== 11) begin n_errors++; $display("FAIL single_beats: got %0d want 11", nb); end
    n_checks++; if (lg_cyc[0] !== rc + 2) begin n_errors++; $display("FAIL single_latency: got %0d want %0d", lg_cyc[0] - rc, 2); end
    n_checks++; if (lg_gid[0] !== 2'd2) begin n_errors++; $display("FAIL single_grant: got %0d want 2", lg_gid[0]); end
    for (int i = 0; i < 11; i++) begin
      n_checks++; if (lg_data[i] !== hw[i]) begin n_errors++; $display("FAIL single_byte%0d: got %h want %h", i, lg_data[i], hw[i]); end
      n_checks++; if (lg_last[i] !== (i == 10)) begin n_errors++; $display("FAIL single_last%0d: got %b want %b", i, lg_last[i], (i == 10)); end
    end
    n_checks++; if (err_cnt !== 0) begin n_errors++; $display("FAIL single_err: got %0d want 0", err_cnt); end
    n = 0;
    do begin step(); if (smp_busy) n++; end while (smp_busy && n < 40);
    n_checks++; if (n !== 12) begin n_errors++; $display("FAIL single_gap: got %0d want 12", n); end
    n_checks++; if (nb !== 11) begin n_errors++; $display("FAIL single_gap_valid: got %0d beats want 11", nb); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [7:0] base [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
    int k, n2;
    do_reset();
    sel8 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      load_pkt(s, 3, base[s]);
      if (s != 2) begin active[s] = 1; cont[s] = 1; end
    end
    drive_src();
    k = 0;
    while (nb < 18 && k < 400) begin step(); k++; end
    n2 = 0;
    for (int i = 0; i < 18; i++) if (lg_gid[i] == 2'd2) n2++;
    for (int p = 0; p < 6; p++) begin
      n_checks++; if (lg_gid[3*p+2] !== exp_g[p]) begin n_errors++; $display("FAIL fair_order%0d: got %0d want %0d", p, lg_gid[3*p+2], exp_g[p]); end
      n_checks++; if (lg_data[3*p+2] !== base[exp_g[p]] + 8'd2) begin n_errors++; $display("FAIL fair_data%0d: got %h want %h", p, lg_data[3*p+2], base[exp_g[p]] + 8'd2); end
    end
    n_checks++; if (n2 !== 0) begin n_errors++; $display("FAIL fair_src2: got %0d grants want 0", n2); end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k, mis;
    do_reset();
    sel8 = 1'b0;
    load_pkt(1, 5, 8'h51);
    active[1] = 1;
    drive_src();
    step();
    step();
    mis = 0;
    k = 0;
    while (nb < 5 && k < 40) begin
      udp_ready = pat[k % 4];
      #1;
      if (m_ready !== (udp_ready ? 4'b0010 : 4'b0000)) mis++;
      step();
      k++;
    end
    udp_ready = 1'b1;
    n_checks++; if (mis !== 0) begin n_errors++; $display("FAIL bp_ready_mirror: got %0d bad cycles want 0", mis); end
    n_checks++; if (k !== 9) begin n_errors++; $display("FAIL bp_cycles: got %0d want 9", k); end
    n_checks++; if (nb !== 5) begin n_errors++; $display("FAIL bp_beats: got %0d want 5", nb); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (lg_data[i] !== 8'h51 + 8'(i)) begin n_errors++; $display("FAIL bp_byte%0d: got %h want %h", i, lg_data[i], 8'h51 + 8'(i)); end
    end
    n_checks++; if (lg_last[4] !== 1'b1 || lg_last[3] !== 1'b0) begin n_errors++; $display("FAIL bp_last: got %b%b want 10", lg_last[4], lg_last[3]); end
  endtask

  task automatic test_truncation();
    int k, n;
    do_reset();
    sel8 = 1'b1;
    load_pkt(0, 10, 8'hA0);
    active[0] = 1;
    drive_src();
    k = 0;
    while (active[0] && k < 60) begin step(); k++; end
    n_checks++; if (active[0] !== 1'b0) begin n_errors++; $display("FAIL trunc_consumed: got %0d of 10 bytes taken want 10", ptr[0]); end
    n_checks++; if (nb !== 8) begin n_errors++; $display("FAIL trunc_beats: got %0d want 8", nb); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (lg_data[i] !== 8'hA0 + 8'(i)) begin n_errors++; $display("FAIL trunc_byte%0d: got %h want %h", i, lg_data[i], 8'hA0 + 8'(i)); end
      n_checks++; if (lg_last[i] !== (i == 7) || lg_err[i] !== (i == 7)) begin n_errors++; $display("FAIL trunc_flags%0d: got last=%b err=%b want %b", i, lg_last[i], lg_err[i], (i == 7)); end
    end
    n_checks++; if (err_cnt !== 1) begin n_errors++; $display("FAIL trunc_err_pulses: got %0d want 1", err_cnt); end
    n = 0;
    do begin step(); if (smp_busy) n++; end while (smp_busy && n < 40);
    n_checks++; if (n !== 12) begin n_errors++; $display("FAIL trunc_gap: got %0d want 12", n); end
    n_checks++; if (nb !== 8) begin n_errors++; $display("FAIL trunc_drain_valid: got %0d beats want 8", nb); end
  endtask

  task automatic test_exact();
    int k;
    do_reset();
    sel8 = 1'b1;
    load_pkt(3, 8, 8'hC0);
    active[3] = 1;
    drive_src();
    k = 0;
    while (active[3] && k < 60) begin step(); k++; end
    n_checks++; if (nb !== 8) begin n_errors++; $display("FAIL exact_beats: got %0d want 8", nb); end
    n_checks++; if (lg_last[7] !== 1'b1 || lg_last[6] !== 1'b0) begin n_errors++; $display("FAIL exact_last: got %b%b want 10", lg_last[7], lg_last[6]); end
    n_checks++; if (err_cnt !== 0) begin n_errors++; $display("FAIL exact_err: got %0d want 0", err_cnt); end
    n_checks++; if (lg_data[7] !== 8'hC7) begin n_errors++; $display("FAIL exact_byte7: got %h want c7", lg_data[7]); end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    sel8 = 1'b0;
    load_pkt(1, 2, 8'h61);
    active[1] = 1;
    drive_src();
    k = 0;
    while (active[1] && k < 40) begin step(); k++; end
    k = 0;
    do begin step(); k++; end while (smp_busy && k < 40);
    clear_log();
    load_pkt(2, 8, 8'h70);
    active[2] = 1;
    drive_src();
    k = 0;
    while (nb < 4 && k < 40) begin step(); k++; end
    rst_n = 1'b0;
    load_pkt(0, 3, 8'h80);
    load_pkt(1, 3, 8'h90);
    load_pkt(3, 3, 8'hB0);
    active[0] = 1; active[1] = 1; active[3] = 1;
    ptr[2] = 0;
    drive_src();
    step();
    #1;
    n_checks++; if (m_busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b want 0", m_busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid: got %b want 0", m_valid); end
    n_checks++; if (m_last !== 1'b0 || m_err !== 1'b0) begin n_errors++; $display("FAIL rmid_last_err: got %b%b want 00", m_last, m_err); end
    n_checks++; if (m_ready !== 4'h0) begin n_errors++; $display("FAIL rmid_src_ready: got %h want 0", m_ready); end
    n_checks++; if (m_data !== 8'h00) begin n_errors++; $display("FAIL rmid_data: got %h want 00", m_data); end
    n_checks++; if (m_gid !== 2'd0) begin n_errors++; $display("FAIL rmid_grant: got %0d want 0", m_gid); end
    rst_n = 1'b1;
    clear_log();
    k = 0;
    while (nb < 1 && k < 40) begin step(); k++; end
    n_checks++; if (lg_gid[0] !== 2'd0) begin n_errors++; $display("FAIL rmid_first_grant: got %0d want 0", lg_gid[0]); end
    n_checks++; if (lg_data[0] !== 8'h80) begin n_errors++; $display("FAIL rmid_first_byte: got %h want 80", lg_data[0]); end
  endtask

  initial begin
    cyc = 0;
    nb = 0;
    err_cnt = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_truncation();
    test_exact();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
